buf_write_arbiter: RTL and testbench

Single-writer front end for the text screen buffer write port (80x30 cells, 7-bit ASCII).
- Merges three sources: a UART byte-stream parser, a host cell-write port with valid/ready, and a full-screen clear sequencer.
- Drives exactly one buffer write per cycle at most.
- Sits between the uart/host logic and the buffer instance in top.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/uart_cmd_parser.sv | 123 ++++++++++++
 rtl/buf_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_buf_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Screen geometry, character widths and FSM encodings shared by
//               the text-buffer write front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int N_COL           = 80;
    localparam int N_ROW           = 30;
    localparam int N_COL_WIDTH     = 7;
    localparam int N_ROW_WIDTH     = 5;
    localparam int N_CHARS_WIDTH   = 7;
    localparam int UART_DATA_WIDTH = 8;

    localparam logic [N_CHARS_WIDTH-1:0] CLR_CHAR = 7'h20;

    typedef enum logic [1:0] {
        P_COL  = 2'd0,
        P_ROW  = 2'd1,
        P_CHAR = 2'd2,
        P_EOL  = 2'd3
    } parser_state_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } top_state_t;

    typedef enum logic [0:0] {
        GRANT_UART = 1'b0,
        GRANT_HOST = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module      : uart_cmd_parser
// Description : Turns the UART byte stream (col, row, char, eol) into one held
//               cell-write triple with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser
    import vga_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       uart_wr_i,
    input  logic [UART_DATA_WIDTH-1:0] uart_data_i,
    input  logic                       take_i,
    output logic                       pend_o,
    output logic [N_COL_WIDTH-1:0]     col_o,
    output logic [N_ROW_WIDTH-1:0]     row_o,
    output logic [N_CHARS_WIDTH-1:0]   char_o,
    output logic                       ovf_o
);

    localparam logic [N_COL_WIDTH-1:0] c_n_col = N_COL_WIDTH'(N_COL);
    localparam logic [N_ROW_WIDTH-1:0] c_n_row = N_ROW_WIDTH'(N_ROW);

    parser_state_t              r_state;
    parser_state_t              w_state_next;
    logic                       r_wr_q;
    logic                       w_accept;
    logic [N_COL_WIDTH-1:0]     w_byte_col;
    logic [N_COL_WIDTH-1:0]     w_col_fold;
    logic [N_ROW_WIDTH-1:0]     w_byte_row;
    logic [N_COL_WIDTH-1:0]     r_col;
    logic [N_ROW_WIDTH-1:0]     r_row;
    logic                       r_row_bad;
    logic                       r_pend;
    logic                       r_ovf;
    logic [N_COL_WIDTH-1:0]     r_hold_col;
    logic [N_ROW_WIDTH-1:0]     r_hold_row;
    logic [N_CHARS_WIDTH-1:0]   r_hold_char;
    logic                       w_unused_msb;

    assign w_accept     = uart_wr_i & ~r_wr_q;
    assign w_byte_col   = uart_data_i[N_COL_WIDTH-1:0];
    assign w_byte_row   = uart_data_i[N_ROW_WIDTH-1:0];
    assign w_unused_msb = uart_data_i[UART_DATA_WIDTH-1];

    // Out-of-range columns fold back by one screen width rather than being dropped.
    assign w_col_fold = (w_byte_col >= c_n_col) ? (w_byte_col - c_n_col) : w_byte_col;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= P_COL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                P_COL:   w_state_next = P_ROW;
                P_ROW:   w_state_next = P_CHAR;
                P_CHAR:  w_state_next = P_EOL;
                P_EOL:   w_state_next = P_COL;
                default: w_state_next = P_COL;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_q      <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_row_bad   <= 1'b0;
            r_pend      <= 1'b0;
            r_ovf       <= 1'b0;
            r_hold_col  <= '0;
            r_hold_row  <= '0;
            r_hold_char <= '0;
        end else begin
            r_wr_q <= uart_wr_i;
            if (take_i) begin
                r_pend <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    P_COL: r_col <= w_col_fold;
                    P_ROW: begin
                        r_row     <= w_byte_row;
                        r_row_bad <= (w_byte_row >= c_n_row);
                    end
                    P_CHAR: begin
                        // A valid triple arriving while one is still held is lost.
                        if (!r_row_bad) begin
                            if (!r_pend) begin
                                r_hold_col  <= r_col;
                                r_hold_row  <= r_row;
                                r_hold_char <= uart_data_i[N_CHARS_WIDTH-1:0];
                                r_pend      <= 1'b1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pend_o = r_pend;
    assign col_o  = r_hold_col;
    assign row_o  = r_hold_row;
    assign char_o = r_hold_char;
    assign ovf_o  = r_ovf;

endmodule

`default_nettype wire

// File: rtl/buf_write_arbiter.sv
// ============================================================================
// Module      : buf_write_arbiter
// Description : Single write port into the text screen buffer, merging UART,
//               host and full-screen clear sources with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_write_arbiter
    import vga_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       uart_wr_i,
    input  logic [UART_DATA_WIDTH-1:0] uart_data_i,
    input  logic                       host_valid_i,
    output logic                       host_ready_o,
    input  logic [N_COL_WIDTH-1:0]     host_col_i,
    input  logic [N_ROW_WIDTH-1:0]     host_row_i,
    input  logic [N_CHARS_WIDTH-1:0]   host_char_i,
    input  logic                       clr_req_i,
    output logic                       clr_busy_o,
    output logic                       wr_en_o,
    output logic [N_COL_WIDTH-1:0]     col_o,
    output logic [N_ROW_WIDTH-1:0]     row_o,
    output logic [N_CHARS_WIDTH-1:0]   din_o,
    output logic                       ovf_o
);

    localparam logic [N_COL_WIDTH-1:0] c_n_col    = N_COL_WIDTH'(N_COL);
    localparam logic [N_ROW_WIDTH-1:0] c_n_row    = N_ROW_WIDTH'(N_ROW);
    localparam logic [N_COL_WIDTH-1:0] c_last_col = N_COL_WIDTH'(N_COL - 1);
    localparam logic [N_ROW_WIDTH-1:0] c_last_row = N_ROW_WIDTH'(N_ROW - 1);

    top_state_t                 r_state;
    top_state_t                 w_state_next;
    grant_t                     r_last_grant;
    logic [N_COL_WIDTH-1:0]     r_clr_col;
    logic [N_ROW_WIDTH-1:0]     r_clr_row;
    logic                       w_clr_last;
    logic                       w_host_ready;
    logic                       w_host_grant;
    logic                       w_uart_grant;
    logic                       w_host_in_range;
    logic                       w_uart_pend;
    logic [N_COL_WIDTH-1:0]     w_uart_col;
    logic [N_ROW_WIDTH-1:0]     w_uart_row;
    logic [N_CHARS_WIDTH-1:0]   w_uart_char;
    logic                       r_wr_en;
    logic [N_COL_WIDTH-1:0]     r_col;
    logic [N_ROW_WIDTH-1:0]     r_row;
    logic [N_CHARS_WIDTH-1:0]   r_din;
    logic                       r_clr_busy;

    uart_cmd_parser u_parser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .uart_wr_i   (uart_wr_i),
        .uart_data_i (uart_data_i),
        .take_i      (w_uart_grant),
        .pend_o      (w_uart_pend),
        .col_o       (w_uart_col),
        .row_o       (w_uart_row),
        .char_o      (w_uart_char),
        .ovf_o       (ovf_o)
    );

    assign w_clr_last      = (r_clr_col == c_last_col) && (r_clr_row == c_last_row);
    assign w_host_in_range = (host_col_i < c_n_col) && (host_row_i < c_n_row);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Host is held off while UART waits its turn, which yields the round-robin.
    always_comb begin
        w_state_next = r_state;
        w_host_ready = 1'b0;
        w_host_grant = 1'b0;
        w_uart_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req_i) begin
                    w_state_next = CLEAR;
                end else begin
                    w_host_ready = !(w_uart_pend && (r_last_grant == GRANT_HOST));
                    w_host_grant = host_valid_i && w_host_ready;
                    w_uart_grant = w_uart_pend && !w_host_grant;
                end
            end
            CLEAR: begin
                if (w_clr_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_en      <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_din        <= '0;
            r_clr_busy   <= 1'b0;
            r_clr_col    <= '0;
            r_clr_row    <= '0;
            r_last_grant <= GRANT_UART;
        end else begin
            r_wr_en    <= 1'b0;
            r_clr_busy <= 1'b0;
            if (r_state == CLEAR) begin
                r_wr_en    <= 1'b1;
                r_clr_busy <= 1'b1;
                r_col      <= r_clr_col;
                r_row      <= r_clr_row;
                r_din      <= CLR_CHAR;
                if (r_clr_col == c_last_col) begin
                    r_clr_col <= '0;
                    r_clr_row <= r_clr_row + 1'b1;
                end else begin
                    r_clr_col <= r_clr_col + 1'b1;
                end
            end else begin
                r_clr_col <= '0;
                r_clr_row <= '0;
                if (w_host_grant) begin
                    r_last_grant <= GRANT_HOST;
                    // Off-screen host cells complete the handshake but write nothing.
                    if (w_host_in_range) begin
                        r_wr_en <= 1'b1;
                        r_col   <= host_col_i;
                        r_row   <= host_row_i;
                        r_din   <= host_char_i;
                    end
                end else if (w_uart_grant) begin
                    r_last_grant <= GRANT_UART;
                    r_wr_en      <= 1'b1;
                    r_col        <= w_uart_col;
                    r_row        <= w_uart_row;
                    r_din        <= w_uart_char;
                end
            end
        end
    end

    assign host_ready_o = w_host_ready;
    assign clr_busy_o   = r_clr_busy;
    assign wr_en_o      = r_wr_en;
    assign col_o        = r_col;
    assign row_o        = r_row;
    assign din_o        = r_din;

endmodule

`default_nettype wire

// File: tb/tb_buf_write_arbiter.sv
// ============================================================================
// Module      : tb_buf_write_arbiter
// Description : Directed self-checking bench for buf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buf_write_arbiter;
    import vga_pkg::*;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic                       uart_wr_i;
    logic [UART_DATA_WIDTH-1:0] uart_data_i;
    logic                       host_valid_i;
    logic                       host_ready_o;
    logic [N_COL_WIDTH-1:0]     host_col_i;
    logic [N_ROW_WIDTH-1:0]     host_row_i;
    logic [N_CHARS_WIDTH-1:0]   host_char_i;
    logic                       clr_req_i;
    logic                       clr_busy_o;
    logic                       wr_en_o;
    logic [N_COL_WIDTH-1:0]     col_o;
    logic [N_ROW_WIDTH-1:0]     row_o;
    logic [N_CHARS_WIDTH-1:0]   din_o;
    logic                       ovf_o;

    int n_checks = 0;
    int n_pass   = 0;

    buf_write_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .uart_wr_i    (uart_wr_i),
        .uart_data_i  (uart_data_i),
        .host_valid_i (host_valid_i),
        .host_ready_o (host_ready_o),
        .host_col_i   (host_col_i),
        .host_row_i   (host_row_i),
        .host_char_i  (host_char_i),
        .clr_req_i    (clr_req_i),
        .clr_busy_o   (clr_busy_o),
        .wr_en_o      (wr_en_o),
        .col_o        (col_o),
        .row_o        (row_o),
        .din_o        (din_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_write(input string tag, input logic [6:0] c, input logic [4:0] r,
                             input logic [6:0] d);
        chk({tag, ".wr_en"}, 32'(wr_en_o), 32'd1);
        chk({tag, ".col"},   32'(col_o),   32'(c));
        chk({tag, ".row"},   32'(row_o),   32'(r));
        chk({tag, ".din"},   32'(din_o),   32'(d));
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data_i = b;
        uart_wr_i   = 1'b1;
        step();
        uart_wr_i   = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] mid_bytes [8];
        int clr_err;
        int rdy_err;
        int idx;

        mid_bytes = '{8'h07, 8'h09, 8'h61, 8'h0A, 8'h08, 8'h0A, 8'h62, 8'h0A};

        rst_i        = 1'b1;
        uart_wr_i    = 1'b0;
        uart_data_i  = '0;
        host_valid_i = 1'b0;
        host_col_i   = '0;
        host_row_i   = '0;
        host_char_i  = '0;
        clr_req_i    = 1'b0;
        step();
        step();
        chk("rst.wr_en", 32'(wr_en_o), 32'd0);
        chk("rst.col",   32'(col_o),   32'd0);
        chk("rst.row",   32'(row_o),   32'd0);
        chk("rst.din",   32'(din_o),   32'd0);
        chk("rst.busy",  32'(clr_busy_o), 32'd0);
        chk("rst.ovf",   32'(ovf_o),   32'd0);
        rst_i = 1'b0;
        step();
        chk("idle.host_ready", 32'(host_ready_o), 32'd1);

        // Basic UART frame: col 5, row 3, 'A'
        send_byte(8'h05);
        send_byte(8'h03);
        uart_data_i = 8'h41;
        uart_wr_i   = 1'b1;
        step();
        chk("t1.no_early_write", 32'(wr_en_o), 32'd0);
        uart_wr_i = 1'b0;
        step();
        chk_write("t1.write", 7'd5, 5'd3, 7'h41);
        step();
        chk("t1.single_pulse", 32'(wr_en_o), 32'd0);
        send_byte(8'h0A);

        // Column fold 85 -> 5, then a bad-row frame that is dropped quietly
        send_byte(8'h55);
        send_byte(8'h02);
        uart_data_i = 8'h42;
        uart_wr_i   = 1'b1;
        step();
        uart_wr_i = 1'b0;
        step();
        chk_write("t2.fold", 7'd5, 5'd2, 7'h42);
        send_byte(8'h0A);
        send_byte(8'h01);
        send_byte(8'h1F);
        send_byte(8'h43);
        chk("t2.badrow.no_write", 32'(wr_en_o), 32'd0);
        send_byte(8'h0A);
        chk("t2.badrow.no_write2", 32'(wr_en_o), 32'd0);
        chk("t2.badrow.no_ovf", 32'(ovf_o), 32'd0);
        chk("t2.col_hold", 32'(col_o), 32'd5);
        chk("t2.din_hold", 32'(din_o), 32'h42);

        // Host and UART collide with last grant UART: host first, then UART
        send_byte(8'h0A);
        send_byte(8'h04);
        uart_data_i = 8'h55;
        uart_wr_i   = 1'b1;
        step();
        chk("t3.pend_no_write", 32'(wr_en_o), 32'd0);
        chk("t3.ready_before", 32'(host_ready_o), 32'd1);
        uart_wr_i    = 1'b0;
        host_valid_i = 1'b1;
        host_col_i   = 7'd20;
        host_row_i   = 5'd7;
        host_char_i  = 7'h48;
        step();
        chk_write("t3.host_first", 7'd20, 5'd7, 7'h48);
        chk("t3.ready_low", 32'(host_ready_o), 32'd0);
        step();
        chk_write("t3.uart_second", 7'd10, 5'd4, 7'h55);
        host_valid_i = 1'b0;
        step();
        chk("t3.idle_after", 32'(wr_en_o), 32'd0);
        send_byte(8'h0A);

        // Off-screen host cell: handshake, no write
        host_valid_i = 1'b1;
        host_col_i   = 7'd80;
        host_row_i   = 5'd0;
        host_char_i  = 7'h30;
        #1;
        chk("hinv.ready", 32'(host_ready_o), 32'd1);
        step();
        chk("hinv.no_write", 32'(wr_en_o), 32'd0);
        host_valid_i = 1'b0;
        step();
        chk("hinv.no_write2", 32'(wr_en_o), 32'd0);

        // Clear sweep with host waiting and two UART triples arriving mid-clear
        host_valid_i = 1'b1;
        host_col_i   = 7'd1;
        host_row_i   = 5'd1;
        host_char_i  = 7'h21;
        clr_req_i    = 1'b1;
        step();
        clr_req_i = 1'b0;
        chk("clr.ready_low", 32'(host_ready_o), 32'd0);
        chk("clr.no_write_yet", 32'(wr_en_o), 32'd0);
        chk("clr.busy_not_yet", 32'(clr_busy_o), 32'd0);
        clr_err = 0;
        rdy_err = 0;
        for (int k = 0; k < 2400; k++) begin
            step();
            if (!(wr_en_o === 1'b1 && col_o === 7'(k % 80) && row_o === 5'(k / 80) &&
                  din_o === 7'h20 && clr_busy_o === 1'b1)) begin
                clr_err++;
            end
            if (k < 2399 && host_ready_o !== 1'b0) begin
                rdy_err++;
            end
            if (k == 0) begin
                chk_write("clr.first", 7'd0, 5'd0, 7'h20);
            end
            if (k == 2399) begin
                chk_write("clr.last", 7'd79, 5'd29, 7'h20);
                chk("clr.last_busy", 32'(clr_busy_o), 32'd1);
                chk("clr.ready_uart_turn", 32'(host_ready_o), 32'd0);
            end
            idx = k - 100;
            if (idx >= 0 && idx < 16) begin
                uart_data_i = mid_bytes[idx / 2];
                uart_wr_i   = (idx % 2 == 0);
            end
        end
        chk("clr.sweep_errors", 32'(clr_err), 32'd0);
        chk("clr.ready_errors", 32'(rdy_err), 32'd0);
        chk("t4.ovf_set", 32'(ovf_o), 32'd1);
        step();
        chk_write("t5.uart_after_clear", 7'd7, 5'd9, 7'h61);
        chk("t5.busy_done", 32'(clr_busy_o), 32'd0);
        chk("t5.ready_host", 32'(host_ready_o), 32'd1);
        step();
        chk_write("t5.host_after_uart", 7'd1, 5'd1, 7'h21);
        host_valid_i = 1'b0;
        step();
        chk("t5.quiet", 32'(wr_en_o), 32'd0);
        chk("t4.ovf_sticky", 32'(ovf_o), 32'd1);

        // Reset during a clear and mid-frame
        clr_req_i = 1'b1;
        step();
        clr_req_i = 1'b0;
        step();
        step();
        send_byte(8'h11);
        chk("t6.clearing", 32'(clr_busy_o), 32'd1);
        rst_i = 1'b1;
        step();
        chk("t6.wr_en", 32'(wr_en_o), 32'd0);
        chk("t6.col",   32'(col_o),   32'd0);
        chk("t6.row",   32'(row_o),   32'd0);
        chk("t6.din",   32'(din_o),   32'd0);
        chk("t6.busy",  32'(clr_busy_o), 32'd0);
        chk("t6.ovf",   32'(ovf_o),   32'd0);
        rst_i = 1'b0;
        step();
        chk("t6.idle_ready", 32'(host_ready_o), 32'd1);
        chk("t6.no_write", 32'(wr_en_o), 32'd0);
        send_byte(8'h0C);
        send_byte(8'h06);
        uart_data_i = 8'h7A;
        uart_wr_i   = 1'b1;
        step();
        uart_wr_i = 1'b0;
        step();
        chk_write("t6.reparse", 7'd12, 5'd6, 7'h7A);
        send_byte(8'h0A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
